seg7_scan_capture: RTL and testbench
====================================

# seg7_scan_capture

Reads the multiplexed, active-low 7-segment display bus driven by the watch's digit drivers and reconstructs the displayed hex digits. Each scan slot is qualified by a stability filter, the segment pattern is inverse-decoded to a nibble, and a full frame is presented with a one-cycle valid strobe. It sits on the display bus as a passive listener for self-test and display readback, and never drives the bus.

## Interface
- `DIGITS`, 6: number of multiplexed digit positions; digit 0 is the rightmost position.
- `STABLE_CYC`, 4: consecutive cycles a (digit, pattern) pair must hold before it is captured; legal range is 2 to 255.

- `clk` in 1: single system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `seg_n` in [0:6]: segment lines, active-low; bit 0 = a through bit 6 = g.
- `dig_n` in [DIGITS-1:0]: digit enables, active-low, nominally one-hot.
- `frame_valid` out 1: one-cycle strobe; a complete frame is on `frame_digits`.
- `frame_digits` out [4*DIGITS-1:0]: digit i occupies bits [4i+3:4i]; the value is held between strobes.
- `frame_err` out 1: qualified with `frame_valid`; set when at least one digit in the frame failed decode.
- `err_mask` out [DIGITS-1:0]: qualified with `frame_valid`; bit i is set when digit i failed decode.

## Operation
- All inputs are in the `clk` domain and are not resynchronized. The inputs are registered once internally (1 cycle).
- Inverse decode table, for `seg_n` a..g:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001101→7
  - 0000000→8, 0000100→9, 0001000→A, 1100000→B, 0110001→C, 1000010→D, 0110000→E, 0111000→F
  - Any other pattern, including blank 1111111, is invalid: nibble 0, error bit set.
- FSM states:
  - IDLE: no enable active, or more than one active. No counting.
  - TRACK: exactly one enable is active. `stab_cnt` counts cycles with an unchanged digit index and pattern.
  - HELD: the current dwell is already captured. Waits for a change in digit or pattern.
- Transitions:
  - IDLE→TRACK when exactly one enable is active; `stab_cnt` loads 1.
  - TRACK→TRACK: if the digit or pattern changes, `stab_cnt` reloads 1. Otherwise it increments.
  - TRACK→HELD on the edge where `stab_cnt` reaches `STABLE_CYC`. That edge writes the nibble to slot i, sets `cap_mask[i]`, and sets or clears `err_acc[i]`.
  - HELD→TRACK when the digit or pattern changes while still exactly one-hot.
  - Any state→IDLE when zero or multiple enables are active. A partial dwell is discarded; `cap_mask` is kept.
- Frame completion happens on the edge where `cap_mask` becomes all ones. That edge:
  - copies the slots to `frame_digits` and `err_acc` to `err_mask`;
  - sets `frame_err` to the OR of `err_acc`;
  - pulses `frame_valid`;
  - clears `cap_mask` and `err_acc`.
- Recapturing a digit already in `cap_mask` overwrites its slot. The latest value wins.
- `stab_cnt` saturates at `STABLE_CYC`. Its width is $clog2(STABLE_CYC+1).

## Timing
- Reset values: `frame_valid`=0, `frame_digits`=0, `frame_err`=0, `err_mask`=0, FSM=IDLE, `cap_mask`=0, `stab_cnt`=0.
- Reset asserted mid-frame discards all partial captures immediately.
- Capture latency: the pattern first appears at the pins on edge k. It is registered at k+1 and captured at k+STABLE_CYC.
- `frame_valid` rises on the same edge as the final digit capture and is high for exactly 1 cycle.
- Pattern glitch: a change lasting fewer than `STABLE_CYC` cycles is never captured. A glitch inside TRACK restarts the count.
- A dwell of exactly `STABLE_CYC` cycles is captured. A dwell of `STABLE_CYC`-1 cycles is not.
- A new frame cannot complete sooner than `DIGITS`×`STABLE_CYC` cycles after the previous strobe.

## Structure
- Shared package `watch_disp_pkg` holds:
  - segment pattern constants SEG_0…SEG_F;
  - SEG_BLANK;
  - the segment bit-order definition;
  - the FSM state enum.
- Sub-module `seg7_to_hex`: combinational pattern→{valid, nibble} decoder. It is reusable by other readback logic.

## Test plan
- Reset mid-frame: assert `reset_n`=0 during a partial frame → all outputs 0, FSM in IDLE, next frame needs all 6 digits again.
- Clean frame: scan digits 5..0 showing 1,2,5,9,0,7, each dwell 8 cycles → `frame_valid` 1 cycle, `frame_digits`=0x125907, `frame_err`=0.
- Stability boundary: digit 0 shows 3 for 3 cycles, then 4 for 4 cycles → slot 0 = 4. Pattern 3 is never captured.
- Invalid pattern: digit 2 shows blank 1111111 in an otherwise clean frame → `err_mask`=6'b000100, `frame_err`=1, nibble 2 = 0.
- Illegal enables: `dig_n`=6'b111100 for 10 cycles → no capture, FSM IDLE. The following legal frame completes normally.
- Overwrite: digit 1 is captured as A, then recaptured as F before the frame completes → bits [7:4]=F at `frame_valid`.

Source files
------------

// File: rtl/watch_disp_pkg.sv
// Shared definitions for the watch display bus: segment bit order,
// active-low segment patterns for hex digits, and capture FSM states.
package watch_disp_pkg;

  // Segment bus bit order: index 0 is segment a through index 6 is segment g.
  // A binary literal written "abcdefg" lands directly on indices 0..6.
  typedef logic [0:6] seg_t;

  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F_BIT = 5,
    SEG_G = 6
  } seg_bit_e;

  // Active-low patterns (0 = segment lit), written a..g.
  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001101;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_A_HEX = 7'b0001000;
  localparam seg_t SEG_B_HEX = 7'b1100000;
  localparam seg_t SEG_C_HEX = 7'b0110001;
  localparam seg_t SEG_D_HEX = 7'b1000010;
  localparam seg_t SEG_E_HEX = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Scan-slot capture FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HELD  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse decoder: active-low 7-segment pattern to hex nibble.
// Unknown patterns (including blank) report valid=0 with nibble 0.
module seg7_to_hex
  import watch_disp_pkg::*;
(
  input  seg_t       seg_n,
  output logic       valid,
  output logic [3:0] nibble
);

  // Table lookup of the displayed glyph
  always_comb begin
    valid  = 1'b1;
    nibble = 4'h0;
    case (seg_n)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A_HEX: nibble = 4'hA;
      SEG_B_HEX: nibble = 4'hB;
      SEG_C_HEX: nibble = 4'hC;
      SEG_D_HEX: nibble = 4'hD;
      SEG_E_HEX: nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      default: begin
        valid  = 1'b0;
        nibble = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Passive listener on the multiplexed active-low 7-segment bus. Each scan
// slot must hold a steady (digit, pattern) pair for STABLE_CYC samples before
// it is decoded into its slot; once every digit has been captured the frame
// is published with a one-cycle frame_valid strobe.
module seg7_scan_capture
  import watch_disp_pkg::*;
#(
  parameter int DIGITS     = 6,
  parameter int STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  seg_t                  seg_n,
  input  logic [DIGITS-1:0]     dig_n,
  output logic                  frame_valid,
  output logic [4*DIGITS-1:0]   frame_digits,
  output logic                  frame_err,
  output logic [DIGITS-1:0]     err_mask
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // True when exactly one bit of the (active-high) enable vector is set.
  function automatic logic is_onehot(input logic [DIGITS-1:0] en);
    int n;
    n = 0;
    for (int i = 0; i < DIGITS; i++) n += int'(en[i]);
    return (n == 1);
  endfunction

  // Dwell counter increment that sticks at STABLE_CYC.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  // ---- stage p0: registered copy of the bus, one sample behind the pins
  seg_t              seg_p0;
  logic [DIGITS-1:0] dig_p0;

  // Capture the bus once; this is both the decode source and the
  // previous-sample reference for change detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_p0 <= SEG_BLANK;
      dig_p0 <= '1;
    end else begin
      seg_p0 <= seg_n;
      dig_p0 <= dig_n;
    end
  end

  // ---- stage p1: qualification FSM, slot capture and frame assembly
  cap_state_e        state;
  logic [CNT_W-1:0]  stab_cnt;
  logic [DIGITS-1:0] cap_mask;
  logic [DIGITS-1:0] err_acc;
  logic [3:0]        slot [DIGITS];

  logic [DIGITS-1:0]   en;
  logic                one;
  logic                changed;
  logic [CNT_W-1:0]    cnt_inc;
  logic                hit;
  logic [DIGITS-1:0]   mask_next;
  logic [DIGITS-1:0]   err_next;
  logic                frame_done;
  logic [4*DIGITS-1:0] frame_next;
  logic                dec_ok;
  logic [3:0]          dec_nib;

  seg7_to_hex u_dec (
    .seg_n  (seg_p0),
    .valid  (dec_ok),
    .nibble (dec_nib)
  );

  // Dwell qualification and next capture bookkeeping
  always_comb begin
    en         = ~dig_n;
    one        = is_onehot(en);
    changed    = (seg_n != seg_p0) || (dig_n != dig_p0);
    cnt_inc    = sat_inc(stab_cnt);
    hit        = (state == ST_TRACK) && one && !changed && (cnt_inc == CNT_MAX);
    mask_next  = cap_mask | (hit ? en : '0);
    err_next   = hit ? ((err_acc & ~en) | (en & {DIGITS{~dec_ok}})) : err_acc;
    frame_done = hit && (&mask_next);
  end

  // Frame image including the digit being captured on this edge
  always_comb begin
    frame_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      frame_next[4*i +: 4] = (hit && en[i]) ? dec_nib : slot[i];
    end
  end

  // Capture FSM with registered frame outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      stab_cnt     <= '0;
      cap_mask     <= '0;
      err_acc      <= '0;
      frame_valid  <= 1'b0;
      frame_digits <= '0;
      frame_err    <= 1'b0;
      err_mask     <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (!one) begin
        // Zero or several enables: abandon the dwell, keep captured digits.
        state    <= ST_IDLE;
        stab_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_TRACK;
            stab_cnt <= CNT_ONE;
          end
          ST_TRACK: begin
            if (changed) begin
              stab_cnt <= CNT_ONE;
            end else begin
              stab_cnt <= cnt_inc;
              if (cnt_inc == CNT_MAX) state <= ST_HELD;
            end
          end
          ST_HELD: begin
            if (changed) begin
              state    <= ST_TRACK;
              stab_cnt <= CNT_ONE;
            end
          end
          default: begin
            state    <= ST_IDLE;
            stab_cnt <= '0;
          end
        endcase
      end
      if (hit) begin
        if (frame_done) begin
          cap_mask     <= '0;
          err_acc      <= '0;
          frame_valid  <= 1'b1;
          frame_digits <= frame_next;
          frame_err    <= |err_next;
          err_mask     <= err_next;
        end else begin
          cap_mask <= mask_next;
          err_acc  <= err_next;
        end
      end
    end
  end

  // Slot storage; a recapture simply overwrites the older value
  always_ff @(posedge clk) begin
    for (int i = 0; i < DIGITS; i++) begin
      if (hit && en[i]) slot[i] <= dec_nib;
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with a run-length behavioural model
// checked every cycle, plus literal frame expectations.
module tb_seg7_scan_capture;
  import watch_disp_pkg::*;

  localparam int DIGITS = 6;
  localparam int S      = 4;

  localparam logic [0:6] PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam logic [0:6] BLANK = 7'b1111111;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [0:6]            seg_n;
  logic [DIGITS-1:0]     dig_n;
  logic                  frame_valid;
  logic [4*DIGITS-1:0]   frame_digits;
  logic                  frame_err;
  logic [DIGITS-1:0]     err_mask;

  seg7_scan_capture #(.DIGITS(DIGITS), .STABLE_CYC(S)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .seg_n        (seg_n),
    .dig_n        (dig_n),
    .frame_valid  (frame_valid),
    .frame_digits (frame_digits),
    .frame_err    (frame_err),
    .err_mask     (err_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int                run;
  bit                have_last;
  logic [0:6]        last_seg;
  logic [DIGITS-1:0] last_dig;
  logic [3:0]        m_slot [DIGITS];
  logic [DIGITS-1:0] m_mask, m_err;
  logic              e_valid, e_err;
  logic [DIGITS-1:0] e_mask;
  logic [23:0]       e_dig;

  int                frames_seen = 0;
  logic [23:0]       f_dig;
  logic              f_err;
  logic [DIGITS-1:0] f_mask;

  function automatic int decode(input logic [0:6] p);
    for (int i = 0; i < 16; i++) if (p == PAT[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    logic [DIGITS-1:0] en;
    int d, v;
    if (reset_n !== 1'b1) begin
      run = 0; have_last = 0; m_mask = '0; m_err = '0;
      e_valid = 0; e_err = 0; e_mask = '0; e_dig = '0;
      return;
    end
    e_valid = 0;
    en = ~dig_n;
    if ($countones(en) != 1) begin
      run = 0; have_last = 0;
      return;
    end
    if (have_last && dig_n == last_dig && seg_n == last_seg) run++;
    else run = 1;
    have_last = 1; last_dig = dig_n; last_seg = seg_n;
    if (run == S) begin
      d = 0;
      for (int i = 0; i < DIGITS; i++) if (en[i]) d = i;
      v = decode(seg_n);
      m_slot[d] = (v < 0) ? 4'h0 : v[3:0];
      m_mask[d] = 1'b1;
      m_err[d]  = (v < 0);
      if (&m_mask) begin
        e_valid = 1;
        for (int i = 0; i < DIGITS; i++) e_dig[4*i +: 4] = m_slot[i];
        e_err  = |m_err;
        e_mask = m_err;
        m_mask = '0; m_err = '0;
      end
    end
  endtask

  // Per-cycle comparison after each active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
      check("cycle", {frame_valid, frame_err, err_mask, frame_digits},
                     {e_valid, e_err, e_mask, e_dig});
      if (frame_valid === 1'b1) begin
        frames_seen++;
        f_dig = frame_digits; f_err = frame_err; f_mask = err_mask;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic show(input int d, input logic [0:6] p, input int n);
    @(negedge clk);
    dig_n = ~(DIGITS'(1) << d);
    seg_n = p;
    repeat (n) @(posedge clk);
  endtask

  task automatic scan_frame(input logic [23:0] val, input int n);
    for (int d = DIGITS - 1; d >= 0; d--) show(d, PAT[val[4*d +: 4]], n);
  endtask

  int f0;

  initial begin
    reset_n = 1'b0;
    seg_n   = BLANK;
    dig_n   = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_digits", 32'(frame_digits), 32'd0);
    check("rst_err", 32'({frame_err, err_mask}), 32'd0);
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
    reset_n = 1'b1;

    // Clean frame, dwell 8
    f0 = frames_seen;
    scan_frame(24'h125907, 8);
    @(negedge clk);
    check("clean_cnt", 32'(frames_seen - f0), 32'd1);
    check("clean_digits", 32'(f_dig), 32'h125907);
    check("clean_err", 32'({f_err, f_mask}), 32'd0);
    check("model_clean", 32'(e_dig), 32'h125907);

    // Stability boundary on digit 0: 3 for S-1 cycles, then 4 for S cycles
    f0 = frames_seen;
    show(5, PAT[6], S); show(4, PAT[5], S); show(3, PAT[4], S);
    show(2, PAT[3], S); show(1, PAT[2], S);
    show(0, PAT[3], S - 1);
    show(0, PAT[4], S);
    @(negedge clk);
    check("bound_pulse_hi", 32'(frame_valid), 32'd1);
    check("bound_cnt", 32'(frames_seen - f0), 32'd1);
    check("bound_digits", 32'(f_dig), 32'h654324);
    @(negedge clk);
    check("bound_pulse_lo", 32'(frame_valid), 32'd0);

    // Blank on digit 2
    f0 = frames_seen;
    show(5, PAT[10], S); show(4, PAT[11], S); show(3, PAT[12], S);
    show(2, BLANK, S); show(1, PAT[13], S); show(0, PAT[14], S);
    @(negedge clk);
    check("inval_cnt", 32'(frames_seen - f0), 32'd1);
    check("inval_digits", 32'(f_dig), 32'hABC0DE);
    check("inval_err", 32'(f_err), 32'd1);
    check("inval_mask", 32'(f_mask), 32'b000100);
    check("model_inval", 32'(e_mask), 32'b000100);

    // Two enables active for 10 cycles
    f0 = frames_seen;
    @(negedge clk);
    dig_n = 6'b111100;
    seg_n = PAT[8];
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("illegal_state", 32'(dut.state), 32'(ST_IDLE));
    check("illegal_cnt", 32'(frames_seen - f0), 32'd0);
    check("illegal_capmask", 32'(dut.cap_mask), 32'd0);
    scan_frame(24'h031415, S);
    @(negedge clk);
    check("after_illegal_cnt", 32'(frames_seen - f0), 32'd1);
    check("after_illegal_digits", 32'(f_dig), 32'h031415);

    // Reset in the middle of a frame
    show(5, PAT[7], S); show(4, PAT[7], S); show(3, PAT[7], S);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_digits", 32'(frame_digits), 32'd0);
    check("midrst_flags", 32'({frame_valid, frame_err, err_mask}), 32'd0);
    check("midrst_capmask", 32'(dut.cap_mask), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    f0 = frames_seen;
    show(2, PAT[1], S); show(1, PAT[2], S); show(0, PAT[3], S);
    @(negedge clk);
    check("midrst_partial", 32'(frames_seen - f0), 32'd0);
    show(5, PAT[4], S); show(4, PAT[5], S); show(3, PAT[6], S);
    @(negedge clk);
    check("midrst_cnt", 32'(frames_seen - f0), 32'd1);
    check("midrst_frame", 32'(f_dig), 32'h456123);

    // Digit 1 captured as A, glitched, then recaptured as F
    f0 = frames_seen;
    show(1, PAT[10], S);
    show(5, PAT[9], S); show(4, PAT[8], S); show(3, PAT[7], S); show(2, PAT[6], S);
    show(1, PAT[7], 2);
    show(1, PAT[15], S);
    show(0, PAT[5], S);
    @(negedge clk);
    check("ovw_cnt", 32'(frames_seen - f0), 32'd1);
    check("ovw_digits", 32'(f_dig), 32'h9876F5);
    check("ovw_nib1", 32'(f_dig[7:4]), 32'hF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
